// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: per-stage enables and bubble controls for
// load-use, EX-resolved branches and multi-cycle data-memory waits, plus a
// memory-timeout halt and two saturating performance counters.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             DMRd_ex,
  input  logic             NextPCsrc_ex,
  input  logic             dm_req_me,
  input  logic             dm_ready_me,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exme_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mewb_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [15:0]      flush_count
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  state_e             state_q;
  logic [WaitW-1:0]   wait_cnt_q;
  logic               mem_err_q;
  logic               active_q;  // low until the first clk edge after reset release
  logic [CNT_W-1:0]   stall_q;
  logic [15:0]        flush_q;

  logic rs_match, load_use_hit;
  logic freeze, branch, load_use, live;

  assign rs_match     = (rs1_used_id && (rd_ex == rs1_id)) || (rs2_used_id && (rd_ex == rs2_id));
  assign load_use_hit = DMRd_ex && (rd_ex != 5'd0) && rs_match;
  assign live         = active_q && (state_q != StHalt);

  // Hazard classification in priority order: freeze > branch > load-use
  always_comb begin
    freeze = 1'b0;
    unique case (state_q)
      StRun:     freeze = active_q && dm_req_me && !dm_ready_me;
      StMemWait: freeze = !dm_ready_me;
      default:   freeze = 1'b0;
    endcase
    branch   = live && !freeze && NextPCsrc_ex;
    load_use = live && !freeze && !NextPCsrc_ex && load_use_hit;
  end

  // Mealy control outputs
  always_comb begin
    pc_en      = live;
    ifid_en    = live;
    idex_en    = live;
    exme_en    = live;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mewb_flush = 1'b0;
    if (freeze) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exme_en    = 1'b0;
      mewb_flush = 1'b1;
    end else if (branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign halted       = (state_q == StHalt);
  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

  // Memory-wait FSM with timeout into a permanent halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      active_q <= 1'b1;
      unique case (state_q)
        StRun: begin
          if (freeze) begin
            state_q    <= StMemWait;
            wait_cnt_q <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (dm_ready_me) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q + WaitW'(1) == WaitW'(MEM_TIMEOUT)) begin
            state_q   <= StHalt;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StHalt: state_q <= StHalt;
        default: begin
          state_q    <= StRun;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle and branch-flush counters; HALT cycles are not stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (live && !pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (branch && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

endmodule
